// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit buffer: FSM encoding and UART status layout.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_e;

  // Position of TX ready in the UART status word; the block receives this bit directly.
  localparam int TX_RDY_BIT = 1;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Byte FIFO with wrap-bit pointers. Reports full/empty/level and flags dropped pushes.
module uart_tx_fifo_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  push_data_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ovf_set_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                     (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  // full is the pre-edge value, so a simultaneous pop never makes room for this push.
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign ovf_set_o = push_i & full_o;
  assign rd_data_o = mem_q[rd_ptr_q[ADDR_W-1:0]];

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, do_pop};
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the UART: queues CPU bytes and strobes them out one at
// a time, waiting for TX ready to drop (acknowledge) and rise again between bytes.
//
// state     | meaning
// IDLE      | waiting for a buffered byte and tx_rdy=1
// ISSUE     | uart_write strobe, byte popped, timeout counter cleared
// WAIT_LOW  | waiting for the UART to drop tx_rdy, bounded by ACK_TIMEOUT
// WAIT_HIGH | waiting for tx_rdy to return; drained pulses if nothing is left
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [7:0]        push_data,
  input  logic              clr_err,
  input  logic              tx_rdy,
  output logic              uart_write,
  output logic [7:0]        uart_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              ovf,
  output logic              ack_err,
  output logic              drained
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             ack_err_q, ack_err_d;
  logic             drained_q, drained_d;
  logic             pop;
  logic             ack_timeout;
  logic             ovf_set;
  logic [7:0]       fifo_rd_data;

  uart_tx_fifo_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (8)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .rd_data_o   (fifo_rd_data),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (level),
    .ovf_set_o   (ovf_set)
  );

  // Next state, byte capture, timeout counting and flag updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    pop         = 1'b0;
    ack_timeout = 1'b0;
    drained_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && tx_rdy) begin
          state_d = ISSUE;
          // Captured here so the data is registered and valid alongside the strobe.
          data_d  = fifo_rd_data;
        end
      end
      ISSUE: begin
        pop     = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!tx_rdy) begin
          state_d = WAIT_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
            ack_timeout = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (tx_rdy) begin
          state_d   = IDLE;
          drained_d = empty;
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d     = ovf_set | (ovf_q & ~clr_err);
    ack_err_d = ack_timeout | (ack_err_q & ~clr_err);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      ack_err_q <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      ack_err_q <= ack_err_d;
      drained_q <= drained_d;
    end
  end

  assign uart_write = (state_q == ISSUE);
  assign uart_data  = data_q;
  assign ovf        = ovf_q;
  assign ack_err    = ack_err_q;
  assign drained    = drained_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple UART ready/ack model.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       clr_err;
  logic       tx_rdy;
  logic       uart_write;
  logic [7:0] uart_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       ovf;
  logic       ack_err;
  logic       drained;

  logic       tb_rdy;
  logic       uart_auto;
  logic       m_rdy;
  logic       m_drop;
  int         m_cnt;
  logic [7:0] strobes[$];
  int         drained_cnt;
  int         checks;
  int         errors;
  int         found;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4), .ACK_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .clr_err    (clr_err),
    .tx_rdy     (tx_rdy),
    .uart_write (uart_write),
    .uart_data  (uart_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .ovf        (ovf),
    .ack_err    (ack_err),
    .drained    (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign tx_rdy = uart_auto ? m_rdy : tb_rdy;

  // UART model: tx_rdy drops one cycle after a strobe and returns 20 cycles later.
  initial begin
    m_rdy = 1'b1; m_drop = 1'b0; m_cnt = 0;
  end
  always @(negedge clk) begin
    if (!uart_auto) begin
      m_rdy = 1'b1; m_drop = 1'b0; m_cnt = 0;
    end else if (m_drop) begin
      m_rdy = 1'b0; m_drop = 1'b0; m_cnt = 20;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_rdy = 1'b1;
    end else if (uart_write) begin
      m_drop = 1'b1;
    end
  end

  // Monitor: log every strobe's byte and count drained pulses.
  initial drained_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (uart_write) strobes.push_back(uart_data);
      if (drained) drained_cnt = drained_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    strobes.delete();
    drained_cnt = 0;
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < 2000 && strobes.size() < n; i++) @(negedge clk);
    check("strobe_count", strobes.size(), n);
    repeat (30) @(negedge clk);
  endtask

  function automatic logic [31:0] logged(input int i);
    return (i < strobes.size()) ? {24'd0, strobes[i]} : 32'hDEAD;
  endfunction

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; push = 1'b0; push_data = 8'h00; clr_err = 1'b0;
    tb_rdy = 1'b1; uart_auto = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values, then idle with tx_rdy=1.
    check("rst_uart_write", uart_write, 1'b0);
    check("rst_uart_data", uart_data, 8'h00);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_level", level, 5'd0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_drained", drained, 1'b0);
    repeat (50) @(negedge clk);
    check("idle_no_strobe", strobes.size(), 0);
    check("idle_empty", empty, 1'b1);

    // Three bytes through the UART model.
    clear_log();
    uart_auto = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_data = 8'h41 + 8'(i);
      @(negedge clk);
    end
    push = 1'b0;
    wait_drain(3);
    check("abc_byte0", logged(0), 8'h41);
    check("abc_byte1", logged(1), 8'h42);
    check("abc_byte2", logged(2), 8'h43);
    check("abc_drained", drained_cnt, 1);
    check("abc_level", level, 5'd0);
    check("abc_ack_err", ack_err, 1'b0);

    // Overfill with tx_rdy low, then drain 16 bytes.
    uart_auto = 1'b0; tb_rdy = 1'b0;
    clear_log();
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      push = 1'b1; push_data = 8'h10 + 8'(i);
      @(negedge clk);
    end
    push = 1'b0;
    check("ovf_full", full, 1'b1);
    check("ovf_level", level, 5'd16);
    check("ovf_flag", ovf, 1'b1);
    check("ovf_no_strobe", strobes.size(), 0);
    uart_auto = 1'b1;
    wait_drain(16);
    for (int i = 0; i < 16; i++) check("ovf_order", logged(i), 8'h10 + i);
    check("ovf_drained", drained_cnt, 1);
    check("ovf_level_end", level, 5'd0);
    check("ovf_sticky", ovf, 1'b1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ovf_cleared", ovf, 1'b0);

    // tx_rdy stuck high: acknowledge timeout.
    uart_auto = 1'b0; tb_rdy = 1'b1;
    clear_log();
    @(negedge clk);
    push = 1'b1; push_data = 8'h55;
    @(negedge clk);
    push = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (uart_write) begin found = 1; break; end
      @(negedge clk);
    end
    check("to_strobe_seen", found, 1);
    check("to_data", uart_data, 8'h55);
    repeat (8) @(negedge clk);
    check("to_not_yet", ack_err, 1'b0);
    @(negedge clk);
    check("to_ack_err", ack_err, 1'b1);
    check("to_level", level, 5'd0);
    check("to_state_idle", dut.state_q, 2'd0);
    repeat (20) @(negedge clk);
    check("to_one_strobe", strobes.size(), 1);
    check("to_data_hold", uart_data, 8'h55);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("to_cleared", ack_err, 1'b0);

    // Reset during WAIT_HIGH with 5 bytes still buffered.
    tb_rdy = 1'b0;
    clear_log();
    for (int i = 0; i < 6; i++) begin
      push = 1'b1; push_data = 8'h61 + 8'(i);
      @(negedge clk);
    end
    push = 1'b0;
    tb_rdy = 1'b1;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_write) begin found = 1; break; end
    end
    tb_rdy = 1'b0;
    check("rwh_strobe_seen", found, 1);
    repeat (2) @(negedge clk);
    check("rwh_state", dut.state_q, 2'd3);
    check("rwh_level", level, 5'd5);
    #2 rst = 1'b1;
    #1;
    check("rwh_uart_data", uart_data, 8'h00);
    check("rwh_level0", level, 5'd0);
    check("rwh_empty", empty, 1'b1);
    check("rwh_uart_write", uart_write, 1'b0);
    check("rwh_state_idle", dut.state_q, 2'd0);
    @(negedge clk);
    rst = 1'b0; tb_rdy = 1'b1;
    clear_log();
    repeat (30) @(negedge clk);
    check("rwh_no_strobe", strobes.size(), 0);

    // Full FIFO, FSM in ISSUE, push and clr_err together: push dropped, set wins.
    tb_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; push_data = 8'h70 + 8'(i);
      @(negedge clk);
    end
    push = 1'b0;
    check("fi_full", full, 1'b1);
    clear_log();
    tb_rdy = 1'b1;
    @(negedge clk);
    check("fi_in_issue", uart_write, 1'b1);
    push = 1'b1; push_data = 8'hEE; clr_err = 1'b1; tb_rdy = 1'b0;
    @(negedge clk);
    push = 1'b0; clr_err = 1'b0;
    check("fi_level15", level, 5'd15);
    check("fi_ovf", ovf, 1'b1);
    check("fi_not_full", full, 1'b0);
    uart_auto = 1'b1;
    wait_drain(16);
    for (int i = 0; i < 16; i++) check("fi_order", logged(i), 8'h70 + i);
    check("fi_level_end", level, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
